// File: rtl/manual_setpoint_ctrl_if.sv
// Operator-entry and set-point output bundle for manual_setpoint_ctrl.
// master = operator front end / actuator side, slave = the controller.
interface manual_setpoint_ctrl_if #(
    parameter int ANGLE_W = 5,
    parameter int REFL_N  = 1
);
    logic               enable;
    logic [ANGLE_W-1:0] angle;
    logic               angle_set;
    logic [REFL_N-1:0]  refl;
    logic               refl_set;
    logic               enter;
    logic               cancel;
    logic [ANGLE_W-1:0] angle_out;
    logic [REFL_N-1:0]  refl_out;
    logic               done;
    logic               busy;
    logic [1:0]         err;

    modport master (
        output enable, angle, angle_set, refl, refl_set, enter, cancel,
        input  angle_out, refl_out, done, busy, err
    );

    modport slave (
        input  enable, angle, angle_set, refl, refl_set, enter, cancel,
        output angle_out, refl_out, done, busy, err
    );
endinterface

// File: rtl/manual_setpoint_ctrl.sv
// Manual set-point entry FSM: angle -> reflector -> confirm, with range check,
// idle timeout and atomic commit. Optional angle ramping under `SLEW_LIMIT_EN`.
module manual_setpoint_ctrl #(
    parameter int ANGLE_W   = 5,
    parameter int ANGLE_MAX = 24,
    parameter int REFL_N    = 1,
    parameter int TIMEOUT   = 1000,
    parameter int SLEW_DIV  = 4
) (
    input  logic                   clk,
    input  logic                   res,
    manual_setpoint_ctrl_if.slave  bus
);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]   T_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [ANGLE_W-1:0] A_MAX  = ANGLE_W'(ANGLE_MAX);

    typedef enum logic [1:0] {IDLE, ANGLE, REFL, CONFIRM} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               as_q, as_d, rs_q, rs_d, ent_q, ent_d;
    logic [ANGLE_W-1:0] sh_angle_q, sh_angle_d;
    logic [REFL_N-1:0]  sh_refl_q, sh_refl_d;
    logic [ANGLE_W-1:0] target_q, target_d;
    logic [REFL_N-1:0]  refl_out_q, refl_out_d;
    logic               done_q, done_d;
    logic [1:0]         err_q, err_d;
    logic               as_edge, rs_edge, ent_edge;

    assign as_edge  = bus.angle_set & ~as_q;
    assign rs_edge  = bus.refl_set  & ~rs_q;
    assign ent_edge = bus.enter     & ~ent_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        as_d       = bus.angle_set;
        rs_d       = bus.refl_set;
        ent_d      = bus.enter;
        sh_angle_d = sh_angle_q;
        sh_refl_d  = sh_refl_q;
        target_d   = target_q;
        refl_out_d = refl_out_q;
        done_d     = 1'b0;
        err_d      = err_q;

        if (state_q == IDLE) begin
            cnt_d = '0;
            if (bus.enable) state_d = ANGLE;
        end else if (bus.cancel || !bus.enable) begin
            state_d    = IDLE;
            cnt_d      = '0;
            err_d      = 2'd3;
            sh_angle_d = '0;
            sh_refl_d  = '0;
        end else if (cnt_q == T_LAST) begin
            state_d    = IDLE;
            cnt_d      = '0;
            err_d      = 2'd2;
            sh_angle_d = '0;
            sh_refl_d  = '0;
        end else begin
            unique case (state_q)
                ANGLE: if (as_edge) begin
                    // A rejected angle is not an accepted strobe; the idle clock keeps running.
                    if (bus.angle <= A_MAX) begin
                        sh_angle_d = bus.angle;
                        state_d    = REFL;
                        cnt_d      = '0;
                    end else begin
                        err_d = 2'd1;
                    end
                end
                REFL: if (rs_edge) begin
                    sh_refl_d = bus.refl;
                    state_d   = CONFIRM;
                    cnt_d     = '0;
                end
                CONFIRM: if (ent_edge) begin
                    target_d   = sh_angle_q;
                    refl_out_d = sh_refl_q;
                    done_d     = 1'b1;
                    err_d      = 2'd0;
                    state_d    = IDLE;
                    cnt_d      = '0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            as_q       <= 1'b0;
            rs_q       <= 1'b0;
            ent_q      <= 1'b0;
            sh_angle_q <= '0;
            sh_refl_q  <= '0;
            target_q   <= '0;
            refl_out_q <= '0;
            done_q     <= 1'b0;
            err_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            as_q       <= as_d;
            rs_q       <= rs_d;
            ent_q      <= ent_d;
            sh_angle_q <= sh_angle_d;
            sh_refl_q  <= sh_refl_d;
            target_q   <= target_d;
            refl_out_q <= refl_out_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

`ifdef SLEW_LIMIT_EN
    localparam int DIV_W = $clog2(SLEW_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SLEW_DIV - 1);

    logic [ANGLE_W-1:0] angle_q, angle_d;
    logic [DIV_W-1:0]   div_q, div_d;

    // Ramp always starts from the current output, so a retarget never jumps.
    always_comb begin
        angle_d = angle_q;
        div_d   = div_q + DIV_W'(1);
        if (angle_q == target_q) begin
            div_d = '0;
        end else if (div_q == DIV_LAST) begin
            div_d   = '0;
            angle_d = (angle_q < target_q) ? angle_q + ANGLE_W'(1) : angle_q - ANGLE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            angle_q <= '0;
            div_q   <= '0;
        end else begin
            angle_q <= angle_d;
            div_q   <= div_d;
        end
    end

    assign bus.angle_out = angle_q;
    assign bus.busy      = (state_q != IDLE) || (angle_q != target_q);
`else
    // SLEW_DIV only matters when ramping; this empty block keeps it referenced.
    if (SLEW_DIV < 1) begin : g_slew_div_unused
    end

    assign bus.angle_out = target_q;
    assign bus.busy      = (state_q != IDLE);
`endif

    assign bus.refl_out = refl_out_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_manual_setpoint_ctrl.sv
// Directed bench for manual_setpoint_ctrl: vector table for commit/range paths,
// hand sequences for held strobes, cancel, timeout, enable drop and async reset.
module tb_manual_setpoint_ctrl;
    logic clk = 1'b0;
    logic res = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    manual_setpoint_ctrl_if #(.ANGLE_W(5), .REFL_N(2)) bus ();

    manual_setpoint_ctrl #(
        .ANGLE_W(5), .ANGLE_MAX(24), .REFL_N(2), .TIMEOUT(100), .SLEW_DIV(4)
    ) dut (
        .clk(clk),
        .res(res),
        .bus(bus)
    );

    typedef struct {
        logic       en;
        logic [4:0] ang;
        logic       as;
        logic [1:0] rf;
        logic       rs;
        logic       ent;
        logic       can;
        logic [4:0] e_ao;
        logic [1:0] e_ro;
        logic       e_done;
        logic       e_busy;
        logic [1:0] e_err;
    } vec_t;

    vec_t vt[17];

    function automatic vec_t mk(logic en, logic [4:0] ang, logic as, logic [1:0] rf,
                                logic rs, logic ent, logic can, logic [4:0] e_ao,
                                logic [1:0] e_ro, logic e_done, logic e_busy,
                                logic [1:0] e_err);
        vec_t v;
        v.en = en; v.ang = ang; v.as = as; v.rf = rf; v.rs = rs; v.ent = ent;
        v.can = can; v.e_ao = e_ao; v.e_ro = e_ro; v.e_done = e_done;
        v.e_busy = e_busy; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic [4:0] ang, input logic as,
                         input logic [1:0] rf, input logic rs, input logic ent,
                         input logic can);
        bus.enable = en; bus.angle = ang; bus.angle_set = as; bus.refl = rf;
        bus.refl_set = rs; bus.enter = ent; bus.cancel = can;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string nm, input logic [4:0] ao, input logic [1:0] ro,
                           input logic dn, input logic bz, input logic [1:0] er);
        chk({nm, ".angle_out"}, int'(bus.angle_out), int'(ao));
        chk({nm, ".refl_out"},  int'(bus.refl_out),  int'(ro));
        chk({nm, ".done"},      int'(bus.done),      int'(dn));
        chk({nm, ".busy"},      int'(bus.busy),      int'(bz));
        chk({nm, ".err"},       int'(bus.err),       int'(er));
    endtask

    initial begin
        //          en ang as rf rs ent can | ao ro dn bz er
        vt[0]  = mk(1,  0, 0, 0, 0, 0, 0,    0, 0, 0, 1, 0);
        vt[1]  = mk(1, 13, 1, 0, 0, 0, 0,    0, 0, 0, 1, 0);
        vt[2]  = mk(1, 13, 0, 2, 0, 0, 0,    0, 0, 0, 1, 0);
        vt[3]  = mk(1, 13, 0, 2, 1, 0, 0,    0, 0, 0, 1, 0);
        vt[4]  = mk(1, 13, 0, 2, 0, 0, 0,    0, 0, 0, 1, 0);
        vt[5]  = mk(1, 13, 0, 2, 0, 1, 0,   13, 2, 1, 0, 0);
        vt[6]  = mk(1, 13, 0, 2, 0, 0, 0,   13, 2, 0, 1, 0);
        vt[7]  = mk(1, 25, 1, 0, 0, 0, 0,   13, 2, 0, 1, 1);
        vt[8]  = mk(1, 24, 0, 0, 0, 0, 0,   13, 2, 0, 1, 1);
        vt[9]  = mk(1, 24, 1, 0, 0, 0, 0,   13, 2, 0, 1, 1);
        vt[10] = mk(1, 24, 0, 1, 0, 0, 0,   13, 2, 0, 1, 1);
        vt[11] = mk(1, 24, 0, 1, 1, 0, 0,   13, 2, 0, 1, 1);
        vt[12] = mk(1, 24, 0, 1, 0, 0, 0,   13, 2, 0, 1, 1);
        vt[13] = mk(1, 24, 0, 1, 0, 1, 0,   24, 1, 1, 0, 0);
        vt[14] = mk(0, 24, 0, 1, 0, 0, 0,   24, 1, 0, 0, 0);
        vt[15] = mk(0, 24, 0, 1, 0, 1, 0,   24, 1, 0, 0, 0);
        vt[16] = mk(0,  0, 0, 0, 0, 0, 0,   24, 1, 0, 0, 0);

        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk_out("reset", 0, 0, 0, 0, 0);
        res = 1'b0;

        for (int i = 0; i < 17; i++) begin
            drive(vt[i].en, vt[i].ang, vt[i].as, vt[i].rf, vt[i].rs, vt[i].ent, vt[i].can);
            tick();
            chk_out($sformatf("vec%0d", i), vt[i].e_ao, vt[i].e_ro, vt[i].e_done,
                    vt[i].e_busy, vt[i].e_err);
        end

        // Held angle_set: one transition only, enter ignored while in REFL.
        drive(1, 0, 0, 0, 0, 0, 0); tick();
        for (int i = 0; i < 10; i++) begin
            drive(1, 7, 1, 3, 0, 0, 0); tick();
            chk($sformatf("held%0d.done", i), int'(bus.done), 0);
            chk($sformatf("held%0d.busy", i), int'(bus.busy), 1);
        end
        drive(1, 7, 0, 3, 0, 1, 0); tick();
        chk_out("held_enter_in_refl", 24, 1, 0, 1, 0);
        drive(1, 7, 0, 3, 0, 0, 0); tick();
        drive(1, 7, 0, 3, 1, 0, 0); tick();
        drive(1, 7, 0, 3, 0, 0, 0); tick();
        drive(1, 7, 0, 3, 0, 1, 0); tick();
        chk_out("held_commit", 7, 3, 1, 0, 0);
        drive(0, 7, 0, 3, 0, 1, 0); tick();
        chk_out("held_after", 7, 3, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0); tick();

        // Cancel in CONFIRM.
        drive(1, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 20, 1, 0, 0, 0, 0); tick();
        drive(1, 20, 0, 0, 0, 0, 0); tick();
        drive(1, 20, 0, 0, 1, 0, 0); tick();
        drive(1, 20, 0, 0, 0, 0, 0); tick();
        chk_out("pre_cancel", 7, 3, 0, 1, 0);
        drive(1, 20, 0, 0, 0, 0, 1); tick();
        chk_out("cancel", 7, 3, 0, 0, 3);
        drive(0, 0, 0, 0, 0, 0, 0); tick();

        // Timeout: 100 idle cycles after entering ANGLE.
        drive(1, 0, 0, 0, 0, 0, 0); tick();
        for (int i = 0; i < 99; i++) tick();
        chk_out("timeout_m1", 7, 3, 0, 1, 3);
        tick();
        chk_out("timeout", 7, 3, 0, 0, 2);
        drive(0, 0, 0, 0, 0, 0, 0); tick();

        // Enable drop mid-entry.
        drive(1, 0, 0, 0, 0, 0, 0); tick();
        chk("endrop_pre.busy", int'(bus.busy), 1);
        drive(0, 0, 0, 0, 0, 0, 0); tick();
        chk_out("endrop", 7, 3, 0, 0, 3);

        // Asynchronous reset mid-REFL.
        drive(1, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 10, 1, 0, 0, 0, 0); tick();
        drive(1, 10, 0, 0, 0, 0, 0); tick();
        chk_out("pre_reset", 7, 3, 0, 1, 3);
        #2 res = 1'b1;
        #1;
        chk_out("async_reset", 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        res = 1'b0;
        tick();
        chk_out("post_reset", 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
